led_blinker_bank: RTL and testbench
===================================

LED_BLINKER_BANK -- requirements
Module: led_blinker_bank

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of LED channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: interval/counter width, 2..16.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-004 SHALL have parameter INIT_INTERVALS, default all channels 9: packed N_CH*CNT_W reset intervals, channel 0 in the LSBs.
REQ-005 SHALL have parameter INIT_MODES, default all channels 2'b01: packed N_CH*2 reset modes.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rstbtn  in  1  reset, asynchronous, active-high.
REQ-008 enable  in  1  global run; when low, all counters and the LFSR hold and leds read 0.
REQ-009 cfg_we  in  1  one-cycle configuration write strobe.
REQ-010 cfg_ch  in  4  target channel of the write.
REQ-011 cfg_mode  in  2  00 OFF, 01 FIXED, 10 RANDOM, 11 SOLID.
REQ-012 cfg_interval  in  CNT_W  FIXED: period minus 1; RANDOM: mask applied to LFSR bits.
REQ-013 leds  out  N_CH  registered per-channel LED outputs.

Function
REQ-014 Each channel SHALL hold mode, interval, counter (CNT_W) and target (CNT_W) registers.
REQ-015 FIXED: target = interval. On an enabled edge, if counter == target, counter <= 0 and led <= 1; otherwise counter <= counter+1 and led <= 0. Period = interval+1 cycles; each pulse is one cycle wide.
REQ-016 FIXED with interval 0 SHALL hold the led high on every enabled cycle.
REQ-017 RANDOM: same counting rule as FIXED, except target reloads on every pulse and on the write that selects RANDOM.
REQ-018 RANDOM reload value: (LFSR rotated left by 3*ch, low CNT_W bits) AND interval; a result of 0 SHALL become 1.
REQ-019 LFSR: shared 16-bit Galois generator, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifted right once per enabled edge.
REQ-020 The LFSR SHALL never reach 0.
REQ-021 OFF: led 0, counter held at 0.
REQ-022 SOLID: led 1 while enable is high, counter held at 0.
REQ-023 cfg_we with cfg_ch < N_CH SHALL load mode and interval on that edge and clear counter and led, overriding any pulse due the same cycle. The channel's first pulse SHALL follow target+1 edges later.
REQ-024 cfg_we with cfg_ch >= N_CH SHALL be ignored.
REQ-025 Writes SHALL be accepted even when enable is low.
REQ-026 Channels SHALL be independent; simultaneous pulses on several channels SHALL all be honoured.
REQ-027 The counter SHALL never exceed target.
REQ-028 If interval is lowered below the current counter, the write clears the counter, so no wrap-around occurs.
REQ-029 enable falling SHALL freeze counters. enable rising SHALL resume counting from the held values, with no extra pulse.

Reset
REQ-030 While rstbtn is high: leds = 0, counters = 0, LFSR = LFSR_SEED, modes = INIT_MODES, intervals = INIT_INTERVALS.
REQ-031 While rstbtn is high, RANDOM targets SHALL be computed from LFSR_SEED per REQ-018 and FIXED targets SHALL equal their intervals.
REQ-032 Assertion mid-operation SHALL clear leds immediately, without waiting for clk.
REQ-033 After deassertion, counting SHALL start on the first enabled rising edge.

Verification
REQ-034 Defaults, N_CH=3, enable=1, reset released: leds[0] high only after edges 10, 20, 30; leds[1] (interval 4 via write) high after every 5th edge.
REQ-035 Write ch1 FIXED interval 0 -> leds[1] = 1 on every following cycle. Write ch1 OFF -> leds[1] = 0 and stays 0.
REQ-036 Write ch2 RANDOM with mask 0 -> target 1, pulse every 2 cycles. Write ch2 RANDOM with mask 8'hFF -> pulse gaps match a bit-exact LFSR reference model over 1000 cycles, and the LFSR is never 0.
REQ-037 Drop enable for 7 cycles with ch0 counter at 5 -> leds all 0, counter holds 5. After enable returns, the pulse arrives 5 edges later.
REQ-038 Assert rstbtn asynchronously between edges while leds[0] = 1 -> leds = 0 before the next edge; post-release sequence identical to REQ-034.
REQ-039 Write to ch 3 with N_CH=3, and a write coinciding with a pulse edge -> the first changes nothing; the second leaves led 0 and counter 0.

Source files
------------

// File: rtl/led_blinker_bank.sv
// Bank of independently configurable LED blinkers: OFF, FIXED period, RANDOM period, SOLID.
// RANDOM periods come from one shared 16-bit Galois LFSR, rotated differently for each channel.
module led_blinker_bank #(
  parameter int unsigned              N_CH           = 3,
  parameter int unsigned              CNT_W          = 8,
  parameter logic [15:0]              LFSR_SEED      = 16'hACE1,
  parameter logic [N_CH*CNT_W-1:0]    INIT_INTERVALS = {N_CH{CNT_W'(9)}},
  parameter logic [N_CH*2-1:0]        INIT_MODES     = {N_CH{2'b01}}
) (
  input  logic                        clk,
  input  logic                        rstbtn,
  input  logic                        enable,
  input  logic                        cfg_we,
  input  logic [3:0]                  cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [CNT_W-1:0]            cfg_interval,
  output logic [N_CH-1:0]             leds,
  output logic [15:0]                 dbg_lfsr,
  output logic [N_CH*CNT_W-1:0]       dbg_counters
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_SOLID  = 2'b11
  } mode_e;

  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Rotate the shared LFSR by 3*ch so channels draw decorrelated values; zero is bumped to 1.
  function automatic logic [CNT_W-1:0] rand_target(
    input logic [15:0]      lfsr,
    input int unsigned      ch,
    input logic [CNT_W-1:0] mask
  );
    int unsigned      s;
    logic [15:0]      w_rot;
    logic [CNT_W-1:0] w_t;
    s     = (3 * ch) % 16;
    w_rot = (lfsr << s) | (lfsr >> (16 - s));
    w_t   = CNT_W'(w_rot) & mask;
    return (w_t == '0) ? CNT_W'(1) : w_t;
  endfunction

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;

  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    if (w_lfsr_next == 16'h0000) begin
      w_lfsr_next = 16'h0001;
    end
  end

  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      r_lfsr <= SEED_EFF;
    end else if (enable) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign dbg_lfsr = r_lfsr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [1:0]       P_MODE = INIT_MODES[2*g +: 2];
    localparam logic [CNT_W-1:0] P_INT  = INIT_INTERVALS[CNT_W*g +: CNT_W];
    localparam logic [CNT_W-1:0] P_TGT  = (P_MODE == 2'b10) ? rand_target(SEED_EFF, g, P_INT) : P_INT;

    mode_e            r_mode;
    logic [CNT_W-1:0] r_interval;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;
    logic             r_led;
    logic             w_sel;
    logic             w_hit;

    assign w_sel = cfg_we && (cfg_ch == 4'(g));
    assign w_hit = (r_cnt == r_target);

    // A configuration write wins over everything, including a pulse due on the same edge.
    always_ff @(posedge clk or posedge rstbtn) begin
      if (rstbtn) begin
        r_mode     <= mode_e'(P_MODE);
        r_interval <= P_INT;
        r_cnt      <= '0;
        r_target   <= P_TGT;
        r_led      <= 1'b0;
      end else if (w_sel) begin
        r_mode     <= mode_e'(cfg_mode);
        r_interval <= cfg_interval;
        r_cnt      <= '0;
        r_led      <= 1'b0;
        r_target   <= (mode_e'(cfg_mode) == MODE_RANDOM) ?
                      rand_target(r_lfsr, g, cfg_interval) : cfg_interval;
      end else if (!enable) begin
        r_led <= 1'b0;
      end else begin
        case (r_mode)
          MODE_OFF: begin
            r_cnt <= '0;
            r_led <= 1'b0;
          end
          MODE_SOLID: begin
            r_cnt <= '0;
            r_led <= 1'b1;
          end
          default: begin
            if (w_hit) begin
              r_cnt <= '0;
              r_led <= 1'b1;
              if (r_mode == MODE_RANDOM) begin
                r_target <= rand_target(r_lfsr, g, r_interval);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_led <= 1'b0;
            end
          end
        endcase
      end
    end

    // Gating with enable makes the LEDs go dark as soon as the bank is paused.
    assign leds[g]                        = r_led & enable;
    assign dbg_counters[CNT_W*g +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_led_blinker_bank.sv
// Bench for led_blinker_bank: directed scenarios plus randomized writes/enables, checked
// against a period/countdown model with its own LFSR arithmetic.
module tb_led_blinker_bank;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int M_OFF = 0, M_FIXED = 1, M_RANDOM = 2, M_SOLID = 3;

  logic                  clk;
  logic                  rstbtn;
  logic                  enable;
  logic                  cfg_we;
  logic [3:0]            cfg_ch;
  logic [1:0]            cfg_mode;
  logic [CNT_W-1:0]      cfg_interval;
  logic [N_CH-1:0]       leds;
  logic [15:0]           dbg_lfsr;
  logic [N_CH*CNT_W-1:0] dbg_counters;

  int n_checks;
  int n_errors;
  logic [N_CH-1:0] exp_q[$];

  // Model: each channel is a period plus edges remaining until its next pulse.
  int m_mode[N_CH];
  int m_int[N_CH];
  int m_per[N_CH];
  int m_rem[N_CH];
  int m_led[N_CH];
  int m_lfsr;

  led_blinker_bank dut (
    .clk          (clk),
    .rstbtn       (rstbtn),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_interval (cfg_interval),
    .leds         (leds),
    .dbg_lfsr     (dbg_lfsr),
    .dbg_counters (dbg_counters)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int l);
    int n;
    n = l / 2;
    if ((l % 2) == 1) n = n ^ 'hB400;
    return n;
  endfunction

  function automatic int rand_period(input int l, input int ch, input int mask);
    int s;
    int r;
    s = (3 * ch) % 16;
    r = ((l * (1 << s)) + (l / (1 << (16 - s)))) % 65536;
    if (s == 0) r = l;
    r = (r % (1 << CNT_W)) & mask;
    if (r == 0) r = 1;
    return r + 1;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_mode[ch] = M_FIXED;
      m_int[ch]  = 9;
      m_per[ch]  = 10;
      m_rem[ch]  = 10;
      m_led[ch]  = 0;
    end
    m_lfsr = 'hACE1;
  endtask

  task automatic model_edge();
    int lp;
    if (rstbtn) begin
      model_reset();
      return;
    end
    lp = m_lfsr;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (cfg_we && int'(cfg_ch) == ch) begin
        m_mode[ch] = int'(cfg_mode);
        m_int[ch]  = int'(cfg_interval);
        m_led[ch]  = 0;
        m_per[ch]  = (m_mode[ch] == M_RANDOM) ? rand_period(lp, ch, m_int[ch]) : m_int[ch] + 1;
        m_rem[ch]  = m_per[ch];
      end else if (!enable) begin
        m_led[ch] = 0;
      end else if (m_mode[ch] == M_OFF || m_mode[ch] == M_SOLID) begin
        m_led[ch] = (m_mode[ch] == M_SOLID) ? 1 : 0;
        m_rem[ch] = m_per[ch];
      end else begin
        m_rem[ch]--;
        m_led[ch] = (m_rem[ch] == 0) ? 1 : 0;
        if (m_rem[ch] == 0) begin
          if (m_mode[ch] == M_RANDOM) m_per[ch] = rand_period(lp, ch, m_int[ch]);
          m_rem[ch] = m_per[ch];
        end
      end
    end
    if (enable) m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < N_CH; ch++) begin
      check("led", ch, 32'(leds[ch]), (m_led[ch] != 0 && enable && !rstbtn) ? 32'd1 : 32'd0);
      check("cnt", ch, 32'(dbg_counters[ch*CNT_W +: CNT_W]), 32'(m_per[ch] - m_rem[ch]));
    end
    check("lfsr", 0, 32'(dbg_lfsr), 32'(m_lfsr));
    check("lfsr_nz", 0, 32'(dbg_lfsr == 16'h0000), 32'd0);
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_write(input int ch, input int mode, input int iv);
    cfg_we       = 1'b1;
    cfg_ch       = 4'(ch);
    cfg_mode     = 2'(mode);
    cfg_interval = CNT_W'(iv);
    step();
    cfg_we       = 1'b0;
  endtask

  task automatic run_034(input string tag);
    logic [N_CH-1:0] e_v;
    for (int e = 1; e <= 30; e++) begin
      e_v    = '0;
      e_v[0] = (e % 10 == 0);
      e_v[1] = (e > 1) && ((e - 1) % 5 == 0);
      e_v[2] = (e % 10 == 0);
      exp_q.push_back(e_v);
    end
    for (int e = 1; e <= 30; e++) begin
      if (e == 1) begin
        cfg_we = 1'b1; cfg_ch = 4'd1; cfg_mode = 2'd1; cfg_interval = CNT_W'(4);
      end
      step();
      cfg_we = 1'b0;
      e_v = exp_q.pop_front();
      check(tag, e, 32'(leds), 32'(e_v));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstbtn = 1'b1; enable = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_interval = '0;
    model_reset();

    // reset state
    step();
    step();
    check("rst_leds", 0, 32'(leds), 32'd0);
    check("rst_lfsr", 0, 32'(dbg_lfsr), 32'hACE1);
    rstbtn = 1'b0;

    run_034("req034");

    // interval 0 holds the LED high, OFF keeps it dark
    do_write(1, M_FIXED, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("fixed0", k, 32'(leds[1]), 32'd1);
    end
    do_write(1, M_OFF, 5);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("off", k, 32'(leds[1]), 32'd0);
    end

    // RANDOM with mask 0 degenerates to target 1; mask FF follows the LFSR
    do_write(2, M_RANDOM, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("rand_m0", k, 32'(leds[2]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    do_write(2, M_RANDOM, 'hFF);
    for (int k = 0; k < 1000; k++) step();

    // randomized writes (including out-of-range channels) and enable gaps
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      enable = ($urandom_range(0, 7) != 0);
      if (r < 2) begin
        cfg_we       = 1'b1;
        cfg_ch       = (r == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, N_CH - 1));
        cfg_mode     = 2'($urandom_range(0, 3));
        cfg_interval = ($urandom_range(0, 1) == 1) ? CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 7));
      end
      step();
      cfg_we = 1'b0;
    end
    enable = 1'b1;

    // pause with ch0 counter at 5, then resume
    do_write(0, M_FIXED, 9);
    for (int k = 0; k < 5; k++) step();
    check("pause_cnt_pre", 0, 32'(dbg_counters[CNT_W-1:0]), 32'd5);
    enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("pause_leds", k, 32'(leds), 32'd0);
      check("pause_cnt", k, 32'(dbg_counters[CNT_W-1:0]), 32'd5);
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("resume_led0", k, 32'(leds[0]), (k == 5) ? 32'd1 : 32'd0);
    end

    // write to a nonexistent channel, then a write landing on a pulse edge
    do_write(3, M_SOLID, 0);
    do_write(0, M_FIXED, 3);
    for (int k = 0; k < 8 && m_rem[0] != 1; k++) step();
    check("pulse_due", 0, 32'(m_rem[0]), 32'd1);
    do_write(0, M_FIXED, 3);
    check("wr_on_pulse_led", 0, 32'(leds[0]), 32'd0);
    check("wr_on_pulse_cnt", 0, 32'(dbg_counters[CNT_W-1:0]), 32'd0);

    // asynchronous reset while leds[0] is lit
    do_write(0, M_FIXED, 2);
    for (int k = 0; k < 8 && leds[0] !== 1'b1; k++) step();
    check("pre_rst_led0", 0, 32'(leds[0]), 32'd1);
    #1;
    rstbtn = 1'b1;
    #1;
    check("async_rst_leds", 0, 32'(leds), 32'd0);
    check("async_rst_cnt", 0, 32'(dbg_counters), 32'd0);
    step();
    step();
    rstbtn = 1'b0;
    run_034("req038");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
